booth_mul_scheduler: RTL and testbench

BOOTH_MUL_SCHEDULER -- requirements
Module: booth_mul_scheduler

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_step_core.sv | 56 +++++
 rtl/booth_mul_scheduler.sv | 100 ++++++++++
 tb/tb_booth_mul_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the two-requester Booth multiplier scheduler.
package booth_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index of a requester (0 or 1).
  typedef logic req_id_t;

endpackage

// File: rtl/booth_step_core.sv
// Iterative radix-2 Booth datapath: A (WIDTH+1 bits), Q, q_-1 and the multiplicand.
// One Booth step per cycle while step is high; load restarts with fresh operands.
module booth_step_core
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     q_in,
  input  logic [WIDTH-1:0]     m_in,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] mcand_q;
  logic             qm1_q;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;

  // Add/subtract selected by {Q[0], q_-1}; one extra bit keeps -(-2^(W-1)) exact.
  always_comb begin
    m_ext = {mcand_q[WIDTH-1], mcand_q};
    sum   = acc_q;
    case ({mq_q[0], qm1_q})
      2'b10:   sum = acc_q - m_ext;
      2'b01:   sum = acc_q + m_ext;
      default: sum = acc_q;
    endcase
  end

  // Operand load, then arithmetic right shift of {A, Q, q_-1} per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      qm1_q   <= 1'b0;
    end else if (load) begin
      acc_q   <= '0;
      mq_q    <= q_in;
      mcand_q <= m_in;
      qm1_q   <= 1'b0;
    end else if (step) begin
      acc_q <= {sum[WIDTH], sum[WIDTH:1]};
      mq_q  <= {sum[0], mq_q[WIDTH-1:1]};
      qm1_q <= mq_q[0];
    end
  end

  assign product = {acc_q[WIDTH-1:0], mq_q};

endmodule

// File: rtl/booth_mul_scheduler.sv
// Round-robin scheduler sharing one Booth step core between two requesters.
module booth_mul_scheduler
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_q,
  input  logic [WIDTH-1:0]   req0_m,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_q,
  input  logic [WIDTH-1:0]   req1_m,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_id,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  req_id_t         last_q;
  req_id_t         id_q;
  req_id_t         grant;
  logic            idle_ok;
  logic            accept;
  logic            last_step;
  logic [WIDTH-1:0] q_sel;
  logic [WIDTH-1:0] m_sel;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = req0_valid ? 1'b0 : 1'b1;
    end
    idle_ok    = (state_q == IDLE) && !rst;
    req0_ready = idle_ok && req0_valid && (grant == 1'b0);
    req1_ready = idle_ok && req1_valid && (grant == 1'b1);
    accept     = req0_ready || req1_ready;
    q_sel      = (grant == 1'b1) ? req1_q : req0_q;
    m_sel      = (grant == 1'b1) ? req1_m : req0_m;
  end

  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  // Next-state logic for IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, step counter, owner id and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= '0;
        id_q   <= grant;
        last_q <= grant;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  booth_step_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (state_q == CALC),
    .q_in    (q_sel),
    .m_in    (m_sel),
    .product (res_data)
  );

  assign res_valid = (state_q == DONE);
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Directed bench for booth_mul_scheduler at WIDTH = 8.
module tb_booth_mul_scheduler;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_q = '0, req0_m = '0, req1_q = '0, req1_m = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [2*W-1:0] res_data;
  logic          res_id;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_mul_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_q     (req0_q),
    .req0_m     (req0_m),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_q     (req1_q),
    .req1_m     (req1_m),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a request and hold it until accepted; returns 1 us after the accept edge.
  task automatic send(input bit who, input logic [7:0] q, input logic [7:0] m, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (who) begin req1_valid = 1'b1; req1_q = q; req1_m = m; end
    else begin req0_valid = 1'b1; req0_q = q; req0_m = m; end
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((who ? req1_ready : req0_ready) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; end
    if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Count rising edges until res_valid is seen (bounded).
  task automatic wait_result(output bit seen, output int lat);
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (res_valid === 1'b1) begin seen = 1'b1; lat = i; end
      end
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); #1;
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL ready_in_reset: got %b%b want 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 16'h0 || res_id !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b busy=%b d=%h id=%b want 0 0 0000 0",
               res_valid, busy, res_data, res_id);
    end
  endtask

  task automatic test_single();
    bit ok, seen; int lat;
    send(1'b0, 8'd3, 8'hFC, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_accept: got none want accept"); end
    wait_result(seen, lat);
    total++;
    if (!seen || lat != 8) begin bad++; $display("FAIL single_latency: got %0d want 8", lat); end
    total++;
    if (res_data !== 16'hFFF4) begin bad++; $display("FAIL single_data: got %h want fff4", res_data); end
    total++;
    if (res_id !== 1'b0) begin bad++; $display("FAIL single_id: got %b want 0", res_id); end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL single_return_idle: got busy=%b v=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_corner();
    bit ok, seen; int lat;
    send(1'b1, 8'h80, 8'h80, ok);
    wait_result(seen, lat);
    total++;
    if (!ok || !seen || res_data !== 16'h4000 || res_id !== 1'b1) begin
      bad++; $display("FAIL corner_min_sq: got d=%h id=%b want 4000 1", res_data, res_id);
    end
  endtask

  task automatic test_tie();
    bit seen; int lat;
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_q = 8'd7;  req0_m = 8'd9;
    req1_valid = 1'b1; req1_q = 8'hFB; req1_m = 8'd6;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL tie_first_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++;
    if (req1_ready !== 1'b0) begin bad++; $display("FAIL tie_ready_calc: got %b want 0", req1_ready); end
    wait_result(seen, lat);
    total++;
    if (!seen || res_data !== 16'd63 || res_id !== 1'b0) begin
      bad++; $display("FAIL tie_result0: got d=%h id=%b want 003f 0", res_data, res_id);
    end
    total++;
    if (req1_ready !== 1'b0) begin bad++; $display("FAIL tie_ready_done: got %b want 0", req1_ready); end
    @(posedge clk); #1;
    total++;
    if (req1_ready !== 1'b1) begin bad++; $display("FAIL tie_next_accept: got %b want 1", req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_result(seen, lat);
    total++;
    if (!seen || lat != 8 || res_data !== 16'hFFE2 || res_id !== 1'b1) begin
      bad++; $display("FAIL tie_result1: got d=%h id=%b lat=%0d want ffe2 1 8", res_data, res_id, lat);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b1; req0_q = 8'd2; req0_m = 8'd2;
    req1_valid = 1'b1; req1_q = 8'd3; req1_m = 8'd3;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL tie_second_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(seen, lat);
    total++;
    if (!seen || res_data !== 16'd4 || res_id !== 1'b0) begin
      bad++; $display("FAIL tie_result2: got d=%h id=%b want 0004 0", res_data, res_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok, seen; int lat;
    res_ready = 1'b0;
    send(1'b0, 8'd5, 8'hFD, ok);
    wait_result(seen, lat);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (res_valid !== 1'b1 || res_data !== 16'hFFF1 || res_id !== 1'b0 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold: got v=%b d=%h id=%b busy=%b rdy=%b%b want 1 fff1 0 1 00",
                 res_valid, res_data, res_id, busy, req0_ready, req1_ready);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL backpressure_release: got busy=%b v=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen; int lat;
    send(1'b0, 8'd11, 8'd13, ok);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0 || res_id !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: got busy=%b v=%b d=%h id=%b want 0 0 0000 0",
               busy, res_valid, res_data, res_id);
    end
    wait_result(seen, lat);
    total++;
    if (seen) begin bad++; $display("FAIL reset_mid_pulse: got res_valid after %0d want none", lat); end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL reset_mid_tie: got %b%b want 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_sweep();
    bit ok, seen; int lat;
    logic signed [7:0]  q, m;
    logic signed [15:0] expv;
    logic [7:0] corners [4];
    bit who;
    corners = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    for (int n = 0; n < 1000; n++) begin
      if (n < 16) begin q = corners[n % 4]; m = corners[n / 4]; end
      else begin q = 8'($urandom); m = 8'($urandom); end
      who  = n[0];
      expv = q * m;
      send(who, q, m, ok);
      wait_result(seen, lat);
      total++;
      if (!ok || !seen || res_data !== expv || res_id !== who) begin
        bad++;
        $display("FAIL sweep %0d*%0d: got d=%h id=%b want %h %b", q, m, res_data, res_id, expv, who);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_corner();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
